// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
//   WAY          lanes per fetch bundle
//   HISTORY_BITS width of the branch-predictor table index carried per lane
//   IQ_DEPTH     default queue depth in bundles
//   iq_entry_t   one lane: instruction, pc, predicted next pc, prediction fields
//   iq_bundle_t  WAY lanes pushed/popped together
package inst_queue_pkg;

   localparam int unsigned WAY          = 2;
   localparam int unsigned HISTORY_BITS = 8;
   localparam int unsigned IQ_DEPTH     = 16;

   localparam logic [1:0] IQ_ST_EMPTY = 2'b01;
   localparam logic [1:0] IQ_ST_FULL  = 2'b10;
   localparam logic [1:0] IQ_ST_PART  = 2'b00;

   typedef struct packed {
      logic [31:0]             inst;
      logic [31:0]             pc;
      logic [31:0]             pc_next;
      logic                    br_pred_valid;
      logic                    br_pred_taken;
      logic [31:0]             br_pred_target;
      logic [HISTORY_BITS-1:0] br_pred_index;
   } iq_entry_t;

   typedef iq_entry_t [WAY-1:0] iq_bundle_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a first-word-fall-through FIFO of
// WAY-wide bundles. The head bundle is presented on the per-lane outputs whenever
// the queue is non-empty; a pop is acknowledged on iq_resp in the same cycle.
// flush (redirect) empties the queue in one cycle and wins over push/pop.
//   clk, rst        clock, synchronous active-high reset
//   flush           discard all entries
//   iq_push/wdata   fetch bundle in; iq_full back-pressures fetch
//   iq_pop/iq_resp  decode request / head-bundle-valid acknowledge
//   iq_status       01 empty, 10 full, 00 partial (from registered count)
//   iq_rdata, pc, pc_next, br_pred_*   head bundle, unpacked per lane
//   iq_count        occupancy in bundles
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              iq_push,
   input  iq_bundle_t                        iq_wdata,
   output logic                              iq_full,
   input  logic                              iq_pop,
   output logic [1:0]                        iq_status,
   output logic                              iq_resp,
   output logic [WAY-1:0][31:0]              iq_rdata,
   output logic [WAY-1:0][31:0]              pc,
   output logic [WAY-1:0][31:0]              pc_next,
   output logic [WAY-1:0]                    br_pred_valid,
   output logic [WAY-1:0]                    br_pred_taken,
   output logic [WAY-1:0][31:0]              br_pred_target,
   output logic [WAY-1:0][HISTORY_BITS-1:0]  br_pred_index,
   output logic [$clog2(DEPTH+1)-1:0]        iq_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   iq_bundle_t       mem [DEPTH];
   iq_bundle_t       head_bundle;
   logic             empty;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign iq_full = (count == CNT_W'(DEPTH));
   // A push while full is dropped even if a pop frees a slot this cycle.
   assign push_ok = iq_push & ~iq_full & ~flush;
   // No bypass: a bundle pushed into an empty queue is poppable next cycle.
   assign pop_ok  = iq_pop & ~empty & ~flush;
   assign iq_resp = pop_ok;
   assign iq_count = count;

   // Status decode from registered occupancy only.
   always_comb begin
      iq_status = IQ_ST_PART;
      if (empty)        iq_status = IQ_ST_EMPTY;
      else if (iq_full) iq_status = IQ_ST_FULL;
   end

   // Pointer and occupancy state; pointers wrap naturally mod DEPTH.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok) tail <= tail + PTR_W'(1);
         if (pop_ok)  head <= head + PTR_W'(1);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Bundle storage; contents are not cleared since empty masks the outputs.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[tail] <= iq_wdata;
   end

   assign head_bundle = empty ? '0 : mem[head];

   // Fan the head bundle out per lane.
   always_comb begin
      for (int l = 0; l < WAY; l++) begin
         iq_rdata[l]       = head_bundle[l].inst;
         pc[l]             = head_bundle[l].pc;
         pc_next[l]        = head_bundle[l].pc_next;
         br_pred_valid[l]  = head_bundle[l].br_pred_valid;
         br_pred_taken[l]  = head_bundle[l].br_pred_taken;
         br_pred_target[l] = head_bundle[l].br_pred_target;
         br_pred_index[l]  = head_bundle[l].br_pred_index;
      end
   end

endmodule
